// File: rtl/led_serial_monitor.sv
// rtl/led_serial_monitor.sv - loopback monitor recovering latched words from the MiniLED serial stream
`timescale 1ns/1ps
module led_serial_monitor #(
    parameter int WORD_W      = 8,
    parameter int CH_PER_SCAN = 90,
    parameter int SCANS       = 4,
    parameter int ADDR_W      = 9
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_en,
    input  logic              I_dclk,
    input  logic              I_sdi,
    input  logic              I_le,
    input  logic [SCANS-1:0]  I_scan,
    output logic              O_wr_en,
    output logic [ADDR_W-1:0] O_wr_addr,
    output logic [WORD_W-1:0] O_wr_data,
    output logic              O_frame_done,
    output logic              O_bit_err,
    output logic              O_scan_err,
    output logic              O_ovf_err
);
    localparam int SI_W = (SCANS > 1) ? $clog2(SCANS) : 1;
    localparam int CH_W = $clog2(CH_PER_SCAN + 1);
    localparam int BC_W = $clog2(WORD_W + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCANS * CH_PER_SCAN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SCAN, S_RUN} state_t;

    state_t            state_q;
    logic [2:0]        dclk_q;
    logic [2:0]        le_q;
    logic [1:0]        sdi_q;
    logic [SCANS-1:0]  scan1_q, scan2_q, scan3_q;
    logic [WORD_W-1:0] sr_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [CH_W-1:0]   ch_cnt_q;
    logic [SI_W-1:0]   scan_idx_q;
    logic              scan_valid_q;

    logic              dclk_rise, le_rise, le_s, sdi_s, scan_chg, scan_ok;
    logic              bits_ok, ch_ok, commit_ok;
    logic [ADDR_W-1:0] addr_d;

    function automatic logic [SI_W-1:0] enc(input logic [SCANS-1:0] v);
        enc = '0;
        for (int i = 0; i < SCANS; i++) begin
            if (v[i]) enc = SI_W'(i);
        end
    endfunction

    // Stage [1] is the synchronized value, stage [2] its one-cycle delay for edge detect.
    assign dclk_rise = dclk_q[1] & ~dclk_q[2];
    assign le_rise   = le_q[1] & ~le_q[2];
    assign le_s      = le_q[1];
    assign sdi_s     = sdi_q[1];
    assign scan_chg  = (scan2_q != scan3_q);
    assign scan_ok   = $onehot(scan2_q);

    assign bits_ok   = (bit_cnt_q == BC_W'(WORD_W));
    assign ch_ok     = (ch_cnt_q < CH_W'(CH_PER_SCAN));
    assign commit_ok = bits_ok && scan_valid_q && ch_ok;
    assign addr_d    = ADDR_W'(scan_idx_q) * ADDR_W'(CH_PER_SCAN) + ADDR_W'(ch_cnt_q);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q      <= S_IDLE;
            dclk_q       <= '0;
            le_q         <= '0;
            sdi_q        <= '0;
            scan1_q      <= '0;
            scan2_q      <= '0;
            scan3_q      <= '0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            scan_idx_q   <= '0;
            scan_valid_q <= 1'b0;
            O_wr_en      <= 1'b0;
            O_wr_addr    <= '0;
            O_wr_data    <= '0;
            O_frame_done <= 1'b0;
            O_bit_err    <= 1'b0;
            O_scan_err   <= 1'b0;
            O_ovf_err    <= 1'b0;
        end else begin
            dclk_q  <= {dclk_q[1:0], I_dclk};
            le_q    <= {le_q[1:0], I_le};
            sdi_q   <= {sdi_q[0], I_sdi};
            scan1_q <= I_scan;
            scan2_q <= scan1_q;
            scan3_q <= scan2_q;

            O_wr_en      <= 1'b0;
            O_frame_done <= 1'b0;
            O_bit_err    <= 1'b0;
            O_scan_err   <= 1'b0;
            O_ovf_err    <= 1'b0;

            if (!I_en) begin
                state_q      <= S_IDLE;
                sr_q         <= '0;
                bit_cnt_q    <= '0;
                ch_cnt_q     <= '0;
                scan_idx_q   <= '0;
                scan_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_WAIT_SCAN;
                    S_WAIT_SCAN: begin
                        if (scan_chg && scan_ok) begin
                            state_q      <= S_RUN;
                            scan_idx_q   <= enc(scan2_q);
                            scan_valid_q <= 1'b1;
                            ch_cnt_q     <= '0;
                            bit_cnt_q    <= '0;
                            sr_q         <= '0;
                        end
                    end
                    S_RUN: begin
                        if (dclk_rise) begin
                            if (le_s) begin
                                O_bit_err <= 1'b1;
                            end else begin
                                sr_q <= {sr_q[WORD_W-2:0], sdi_s};
                                if (bit_cnt_q != BC_W'(WORD_W + 1)) bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        // Commit sees the pre-change scan context; a scan change below overrides counters.
                        if (le_rise) begin
                            bit_cnt_q <= '0;
                            if (!bits_ok)      O_bit_err  <= 1'b1;
                            if (!scan_valid_q) O_scan_err <= 1'b1;
                            if (!ch_ok)        O_ovf_err  <= 1'b1;
                            if (commit_ok) begin
                                O_wr_en      <= 1'b1;
                                O_wr_data    <= sr_q;
                                O_wr_addr    <= addr_d;
                                O_frame_done <= (addr_d == LAST_ADDR);
                                ch_cnt_q     <= ch_cnt_q + 1'b1;
                            end
                        end
                        if (scan_chg) begin
                            if (scan_ok) begin
                                scan_idx_q   <= enc(scan2_q);
                                scan_valid_q <= 1'b1;
                                ch_cnt_q     <= '0;
                                bit_cnt_q    <= '0;
                                sr_q         <= '0;
                            end else begin
                                O_scan_err   <= 1'b1;
                                scan_valid_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_serial_monitor.sv
// tb/tb_led_serial_monitor.sv - scoreboard bench for led_serial_monitor
`timescale 1ns/1ps
module tb_led_serial_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dclk = 1'b0;
    logic       sdi = 1'b0;
    logic       le = 1'b0;
    logic [3:0] scan = 4'b0000;
    logic       wr_en, frame_done, bit_err, scan_err, ovf_err;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;

    led_serial_monitor dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_dclk(dclk), .I_sdi(sdi),
        .I_le(le), .I_scan(scan), .O_wr_en(wr_en), .O_wr_addr(wr_addr),
        .O_wr_data(wr_data), .O_frame_done(frame_done), .O_bit_err(bit_err),
        .O_scan_err(scan_err), .O_ovf_err(ovf_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [4:0] flags;
        logic [8:0] addr;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done_req = 1'b0;

    localparam logic [4:0] F_WR   = 5'b10000;
    localparam logic [4:0] F_DONE = 5'b01000;
    localparam logic [4:0] F_BIT  = 5'b00100;
    localparam logic [4:0] F_SCAN = 5'b00010;
    localparam logic [4:0] F_OVF  = 5'b00001;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [4:0] got;
        exp_t       e;
        got = {wr_en, frame_done, bit_err, scan_err, ovf_err};
        if (!rst_n) begin
            checks++;
            if (got != 5'b0 || wr_addr != 9'd0 || wr_data != 8'd0) begin
                errors++;
                $display("FAIL reset_outputs got flags=%b addr=%0d data=%h required all zero", got, wr_addr, wr_data);
            end
        end else if (got != 5'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got flags=%b addr=%0d data=%h required none", got, wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (got != e.flags) begin
                    errors++;
                    $display("FAIL event_flags got=%b required=%b (wr,done,bit,scan,ovf)", got, e.flags);
                end
                if (e.flags[4]) begin
                    checks++;
                    if (wr_addr != e.addr || wr_data != e.data) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
                    end
                end
                if (e.lat >= 0) begin
                    checks++;
                    if (cyc != e.lat) begin
                        errors++;
                        $display("FAIL latency got cycle=%0d required cycle=%0d", cyc, e.lat);
                    end
                end
            end
        end
        if (done_req) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events got pending=%0d required 0", exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [4:0] f, input logic [8:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        e.flags = f; e.addr = a; e.data = d; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = d[i]; dclk = 1'b0; tick(2);
            dclk = 1'b1; tick(2);
        end
        dclk = 1'b0; tick(2);
    endtask

    task automatic commit(input logic [4:0] f, input logic [8:0] a, input logic [7:0] d, input bit chk_lat);
        le = 1'b1;
        if (f != 5'b0) push(f, a, d, chk_lat ? cyc + 3 : -1);
        tick(2);
        le = 1'b0; tick(2);
    endtask

    task automatic word(input logic [7:0] d, input logic [4:0] f, input logic [8:0] a);
        send_bits(d, 8);
        commit(f, a, d, 1'b0);
    endtask

    task automatic set_scan(input logic [3:0] v, input logic [4:0] f);
        if (f != 5'b0) push(f, 9'd0, 8'd0, -1);
        scan = v; tick(4);
    endtask

    task automatic restart();
        en = 1'b0; scan = 4'b0000; tick(4);
        en = 1'b1; tick(2);
    endtask

    initial begin
        logic [8:0] a;
        // Reset held while the stream toggles.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dclk = ~dclk; sdi = ~sdi; le = (i == 3); tick(2);
        end
        dclk = 1'b0; le = 1'b0; sdi = 1'b0;
        rst_n = 1'b1; tick(2);

        // No scan change yet: a full word must not be written.
        word(8'hFF, 5'b0, 9'd0);

        set_scan(4'b0001, 5'b0);
        send_bits(8'hA5, 8);
        commit(F_WR, 9'd0, 8'hA5, 1'b1);

        // Full frame, data = low address byte.
        restart();
        for (int s = 0; s < 4; s++) begin
            set_scan(4'b0001 << s, 5'b0);
            for (int c = 0; c < 90; c++) begin
                a = 9'(s * 90 + c);
                word(a[7:0], (a == 9'd359) ? (F_WR | F_DONE) : F_WR, a);
            end
        end

        // Short word, then recovery at the same address.
        restart();
        set_scan(4'b0001, 5'b0);
        send_bits(8'h55, 7);
        commit(F_BIT, 9'd0, 8'd0, 1'b0);
        word(8'h3C, F_WR, 9'd0);

        // DCLK rise while LE high after a good commit.
        send_bits(8'h81, 8);
        le = 1'b1;
        push(F_WR, 9'd1, 8'h81, cyc + 3);
        tick(2);
        push(F_BIT, 9'd0, 8'd0, -1);
        dclk = 1'b1; tick(2);
        dclk = 1'b0; tick(2);
        le = 1'b0; tick(2);

        // Invalid scan, commit while invalid, recovery on scan 0100.
        set_scan(4'b0011, F_SCAN);
        word(8'h42, F_SCAN, 9'd0);
        set_scan(4'b0100, 5'b0);
        word(8'h99, F_WR, 9'd180);

        // Scan change and LE rise together: commit uses old context.
        send_bits(8'h77, 8);
        scan = 4'b1000;
        commit(F_WR, 9'd181, 8'h77, 1'b1);
        tick(2);
        word(8'h11, F_WR, 9'd270);

        // Channel overflow on scan 0001.
        restart();
        set_scan(4'b0001, 5'b0);
        for (int c = 0; c < 90; c++) word(8'(c), F_WR, 9'(c));
        word(8'hEE, F_OVF, 9'd0);

        // Enable dropped mid-scan.
        restart();
        set_scan(4'b0010, 5'b0);
        word(8'hD0, F_WR, 9'd90);
        word(8'hD1, F_WR, 9'd91);
        word(8'hD2, F_WR, 9'd92);
        en = 1'b0; tick(4);
        en = 1'b1; tick(2);
        word(8'h5A, 5'b0, 9'd0);
        set_scan(4'b0100, 5'b0);
        word(8'h6B, F_WR, 9'd180);

        tick(20);
        done_req = 1'b1;
    end
endmodule
